// File: rtl/uart_byte_buffer.sv
// uart_byte_buffer: elastic circular FIFO between the UART receiver and the
// UART transmitter. Good bytes are queued on rx_done; the launch FSM hands
// them to the transmitter one at a time with a single-cycle tx_start pulse.
// tx_data stays stable until the transmitter reports tx_done.
module uart_byte_buffer #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_done,
  input  logic                       rx_valid,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  input  logic                       clr_overflow,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       drop_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          overflow_q, overflow_d;
  logic          drop_err_q, drop_err_d;
  logic [7:0]    mem_q [DEPTH];

  logic          empty_s;
  logic          full_s;
  logic          pop_s;
  logic          push_s;
  logic          ovf_set_s;
  logic          drop_set_s;

  assign empty_s = (count_q == {(AW+1){1'b0}});
  assign full_s  = (count_q == FULL_CNT);

  // Launch FSM: pop only when idle with data available and transmitter free.
  always_comb begin
    state_d    = state_q;
    pop_s      = 1'b0;
    tx_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_s && !tx_busy) begin
          pop_s      = 1'b1;
          tx_start_d = 1'b1;
          state_d    = START;
        end else begin
          state_d    = IDLE;
        end
      end
      START: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Push decision, pointer/count update and sticky error flags.
  always_comb begin
    push_s     = 1'b0;
    ovf_set_s  = 1'b0;
    drop_set_s = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tx_data_d  = tx_data_q;
    overflow_d = overflow_q;
    drop_err_d = drop_err_q;

    if (rx_done) begin
      if (!rx_valid) begin
        drop_set_s = 1'b1;
      end else if (!full_s || pop_s) begin
        // a same-cycle pop frees the slot, so a full FIFO still accepts
        push_s = 1'b1;
      end else begin
        ovf_set_s = 1'b1;
      end
    end else begin
      push_s = 1'b0;
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      tx_data_d = mem_q[rd_ptr_q];
    end else begin
      rd_ptr_d  = rd_ptr_q;
      tx_data_d = tx_data_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // a new event wins over a coincident clear
    if (ovf_set_s) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    if (drop_set_s) begin
      drop_err_d = 1'b1;
    end else if (clr_overflow) begin
      drop_err_d = 1'b0;
    end else begin
      drop_err_d = drop_err_q;
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {(AW+1){1'b0}};
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      overflow_q <= 1'b0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
      drop_err_q <= drop_err_d;
    end
  end

  // Byte storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign count    = count_q;
  assign empty    = empty_s;
  assign full     = full_s;
  assign overflow = overflow_q;
  assign drop_err = drop_err_q;

endmodule

// File: tb/tb_uart_byte_buffer.sv
// Self-checking bench for uart_byte_buffer: a queue-based reference model
// predicts every output each cycle; directed scenarios add literal checks.
module tb_uart_byte_buffer;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       rx_valid = 1'b0;
  logic       tx_busy = 1'b0;
  logic       tx_done = 1'b0;
  logic       clr_overflow = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       drop_err;

  uart_byte_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .rx_valid(rx_valid), .tx_busy(tx_busy), .tx_done(tx_done),
    .clr_overflow(clr_overflow), .tx_start(tx_start), .tx_data(tx_data),
    .count(count), .empty(empty), .full(full), .overflow(overflow),
    .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [7:0] mq [$];
  logic       m_start = 1'b0;   // transmitter is being launched this cycle
  logic       m_wait  = 1'b0;   // launched, waiting for completion
  logic [7:0] m_data  = 8'h00;
  logic       m_ovf   = 1'b0;
  logic       m_drop  = 1'b0;

  // transmitter emulation
  logic       auto_tx = 1'b0;
  int         xmit = 0;
  int         xmit_max = 4;

  int tests = 0;
  int fails = 0;
  int launches = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("count",    int'(count),    mq.size());
    chk("empty",    int'(empty),    int'(mq.size() == 0));
    chk("full",     int'(full),     int'(mq.size() == DEPTH));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("drop_err", int'(drop_err), int'(m_drop));
    chk("tx_start", int'(tx_start), int'(m_start));
    chk("tx_data",  int'(tx_data),  int'(m_data));
  endtask

  task automatic model_reset();
    mq.delete();
    m_start = 1'b0;
    m_wait  = 1'b0;
    m_data  = 8'h00;
    m_ovf   = 1'b0;
    m_drop  = 1'b0;
  endtask

  // one clock cycle: drive inputs, advance model over the edge, compare
  task automatic step(input logic rd, input logic rv, input logic [7:0] d,
                      input logic clr);
    logic pop;
    logic was_full;
    logic set_ovf;
    logic set_drop;
    rx_done = rd;
    rx_valid = rv;
    rx_data = d;
    clr_overflow = clr;
    if (auto_tx) begin
      tx_done = 1'b0;
      if (m_start) begin
        xmit = $urandom_range(1, xmit_max);
      end else if (xmit != 0) begin
        xmit = xmit - 1;
        if (xmit == 0) tx_done = 1'b1;
      end else if (!m_wait && $urandom_range(0, 15) == 0) begin
        tx_done = 1'b1;  // stray completion while nothing is in flight
      end
      tx_busy = (xmit != 0);
    end
    @(posedge clk);
    pop = !m_start && !m_wait && (mq.size() > 0) && !tx_busy;
    was_full = (mq.size() == DEPTH);
    set_ovf = 1'b0;
    set_drop = 1'b0;
    if (pop) m_data = mq.pop_front();
    if (rd) begin
      if (!rv) set_drop = 1'b1;
      else if (!was_full || pop) mq.push_back(d);
      else set_ovf = 1'b1;
    end
    m_ovf  = set_ovf  ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_drop = set_drop ? 1'b1 : (clr ? 1'b0 : m_drop);
    m_wait = m_start || (m_wait && !tx_done);
    m_start = pop;
    #1;
    check_all();
    if (tx_start) launches++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    rst = 1'b0;

    // single byte, latency and hold
    launches = 0;
    step(1'b1, 1'b1, 8'hA5, 1'b0);
    chk("t1_count_after_push", int'(count), 1);
    chk("t1_no_start_yet", int'(tx_start), 0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t1_start", int'(tx_start), 1);
    chk("t1_data", int'(tx_data), 8'hA5);
    chk("t1_count_zero", int'(count), 0);
    tx_busy = 1'b1;
    idle(3);
    chk("t1_hold_data", int'(tx_data), 8'hA5);
    chk("t1_start_low", int'(tx_start), 0);
    tx_done = 1'b1;
    tx_busy = 1'b0;
    idle(1);
    tx_done = 1'b0;
    idle(4);
    chk("t1_single_launch", launches, 1);

    // fill to full, overflow, clear, push+pop when full, drain in order
    tx_busy = 1'b1;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 8'(i), 1'b0);
    chk("t2_count16", int'(count), 16);
    chk("t2_full", int'(full), 1);
    step(1'b1, 1'b1, 8'hFF, 1'b0);
    chk("t2_overflow", int'(overflow), 1);
    chk("t2_count_still16", int'(count), 16);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t2_ovf_cleared", int'(overflow), 0);
    tx_busy = 1'b0;
    launches = 0;
    step(1'b1, 1'b1, 8'hAA, 1'b0);
    chk("t2_pushpop_count", int'(count), 16);
    chk("t2_pushpop_noovf", int'(overflow), 0);
    chk("t2_first_out", int'(tx_data), 8'h00);
    auto_tx = 1'b1;
    xmit = 0;
    xmit_max = 4;
    idle(150);
    chk("t2_drained", int'(empty), 1);
    chk("t2_launch_cnt", launches, 17);

    // wrap-around with shallow occupancy
    begin
      int pushed = 0;
      launches = 0;
      xmit_max = 3;
      for (int i = 0; i < 2000 && pushed < 40; i++) begin
        if (mq.size() < 5 && $urandom_range(0, 1) == 1) begin
          step(1'b1, 1'b1, 8'($urandom), 1'b0);
          pushed++;
        end else begin
          step(1'b0, 1'b0, 8'h00, 1'b0);
        end
      end
      idle(60);
      chk("t3_pushed", pushed, 40);
      chk("t3_launch_cnt", launches, 40);
      chk("t3_noovf", int'(overflow), 0);
      chk("t3_empty", int'(empty), 1);
    end

    // invalid frame drop and clear
    launches = 0;
    step(1'b1, 1'b0, 8'h3C, 1'b0);
    chk("t5_drop", int'(drop_err), 1);
    chk("t5_count0", int'(count), 0);
    idle(3);
    chk("t5_no_launch", launches, 0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t5_drop_cleared", int'(drop_err), 0);

    // reset while waiting on the transmitter with 3 bytes stored
    auto_tx = 1'b0;
    xmit = 0;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    step(1'b1, 1'b1, 8'h11, 1'b0);
    step(1'b1, 1'b1, 8'h22, 1'b0);
    tx_busy = 1'b1;
    step(1'b1, 1'b1, 8'h33, 1'b0);
    step(1'b1, 1'b1, 8'h44, 1'b0);
    chk("t6_count3", int'(count), 3);
    chk("t6_inflight", int'(tx_data), 8'h11);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("t6_rst_count", int'(count), 0);
    chk("t6_rst_empty", int'(empty), 1);
    chk("t6_rst_data", int'(tx_data), 0);
    check_all();
    rx_done = 1'b0;
    tx_busy = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    launches = 0;
    tx_done = 1'b1;
    idle(1);
    tx_done = 1'b0;
    idle(4);
    chk("t6_stale_done", launches, 0);

    // randomized traffic, slow then fast transmitter
    auto_tx = 1'b1;
    xmit = 0;
    xmit_max = 30;
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 7) != 0,
           8'($urandom), $urandom_range(0, 39) == 0);
    xmit_max = 3;
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 7) != 0,
           8'($urandom), $urandom_range(0, 39) == 0);
    idle(200);
    chk("rand_drained", int'(empty), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
